// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory byte write port: takes a length-prefixed
// byte stream, writes it into memory and releases the core. Define IMEM_LOAD_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int unsigned INSTR_SIZE = 145722,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        ebreak_E,
  output logic        instrWrEn,
  output logic [31:0] InstrWrAdd,
  output logic [7:0]  InstrWrData,
  output logic        core_rst,
  output logic        PC_ce,
  output logic        Instr_ce,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(INSTR_SIZE);

  state_t      state;
  state_t      state_next;
  logic [31:0] len_reg;
  logic [31:0] count;
  logic [31:0] len_shift;
  logic        accept;
  logic        payload_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept       = rx_valid && rx_ready;
  // Header is little-endian: shifting in from the top leaves byte 0 in bits 7:0.
  assign len_shift    = {rx_data, len_reg[31:8]};
  assign payload_done = (count == len_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    core_rst   = 1'b1;
    PC_ce      = 1'b0;
    Instr_ce   = 1'b0;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        busy     = 1'b1;
        rx_ready = 1'b1;
        if (accept && (count[1:0] == 2'd3)) begin
          if ((len_shift == 32'd0) || (len_shift > MAX_LEN)) state_next = S_ERR;
          else                                                 state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
        // Once the payload is in, the one extra byte accepted here is the checksum.
        rx_ready = 1'b1;
        if (accept && payload_done) begin
          if (rx_data == csum) state_next = S_RUN;
          else                 state_next = S_ERR;
        end
`else
        rx_ready = !payload_done;
        if (payload_done) state_next = S_RUN;
`endif
      end
      S_RUN: begin
        core_rst = 1'b0;
        PC_ce    = 1'b1;
        Instr_ce = 1'b1;
        done     = 1'b1;
        if (start)         state_next = S_LEN;
        else if (ebreak_E) state_next = S_HALT;
      end
      S_HALT: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) state_next = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Write port is registered, giving each accepted payload byte a strobe exactly one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg     <= 32'd0;
      count       <= 32'd0;
      instrWrEn   <= 1'b0;
      InstrWrAdd  <= BASE_ADDR;
      InstrWrData <= 8'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum        <= 8'd0;
`endif
    end else begin
      instrWrEn <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            len_reg <= len_shift;
            if (count[1:0] == 2'd3) count <= 32'd0;
            else                    count <= count + 32'd1;
          end
        end
        S_LOAD: begin
          if (accept && !payload_done) begin
            instrWrEn   <= 1'b1;
            InstrWrData <= rx_data;
            InstrWrAdd  <= BASE_ADDR + count;
            count       <= count + 32'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum        <= csum ^ rx_data;
`endif
          end
        end
        S_IDLE, S_RUN, S_HALT, S_ERR: begin
          if (start) begin
            len_reg <= 32'd0;
            count   <= 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum    <= 8'd0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random streams against a queue-based write model.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int unsigned TB_SIZE = 48;
  localparam logic [31:0] TB_BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        ebreak_E;
  logic        instrWrEn;
  logic [31:0] InstrWrAdd;
  logic [7:0]  InstrWrData;
  logic        core_rst;
  logic        PC_ce;
  logic        Instr_ce;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] payload[$];

  imem_boot_loader #(
    .INSTR_SIZE(TB_SIZE),
    .BASE_ADDR (TB_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .ebreak_E   (ebreak_E),
    .instrWrEn  (instrWrEn),
    .InstrWrAdd (InstrWrAdd),
    .InstrWrData(InstrWrData),
    .core_rst   (core_rst),
    .PC_ce      (PC_ce),
    .Instr_ce   (Instr_ce),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest expected write, including the cycle it appears in.
  always @(negedge clk) begin
    wr_t e;
    if (instrWrEn === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe got addr=%h data=%h cyc=%0d required no strobe",
                 InstrWrAdd, InstrWrData, cyc);
      end else begin
        e = exp_q.pop_front();
        if (InstrWrAdd !== e.addr || InstrWrData !== e.data || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   InstrWrAdd, InstrWrData, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit wr,
                           input logic [31:0] addr, input bit poke);
    int  n;
    wr_t e;
    if (poke && gap > 0) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_ready_timeout got %b required 1", rx_ready);
    end else if (wr) begin
      e.addr = addr;
      e.data = b;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] len, input int min_gap, input int max_gap,
                          input bit do_start, input bit poke);
    bit         bad;
    logic [7:0] x;
    bad = (len == 32'd0) || (len > TB_SIZE);
    if (do_start) pulse_start();
    for (int i = 0; i < 4; i++)
      send_byte(len[8*i +: 8], $urandom_range(min_gap, max_gap), 1'b0, 32'd0, poke);
    if (bad) begin
      checks++;
      if (err !== 1'b1 || core_rst !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL len_error got err=%b core_rst=%b rx_ready=%b busy=%b done=%b required 1 1 0 0 0",
                 err, core_rst, rx_ready, busy, done);
      end
    end else begin
      x = 8'd0;
      for (int i = 0; i < int'(len); i++) begin
        send_byte(payload[i], $urandom_range(min_gap, max_gap), 1'b1, TB_BASE + 32'(i), poke);
        x ^= payload[i];
      end
      checks++;
      if (core_rst !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL last_strobe_cycle got core_rst=%b busy=%b required 1 1", core_rst, busy);
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_byte(x, 0, 1'b0, 32'd0, 1'b0);
`else
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rx_ready_drop got %b required 0", rx_ready);
      end
      @(negedge clk);
`endif
      checks++;
      if (core_rst !== 1'b0 || PC_ce !== 1'b1 || Instr_ce !== 1'b1 || done !== 1'b1 ||
          busy !== 1'b0 || rx_ready !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_entry got core_rst=%b PC_ce=%b Instr_ce=%b done=%b busy=%b rx_ready=%b err=%b required 0 1 1 1 0 0 0",
                 core_rst, PC_ce, Instr_ce, done, busy, rx_ready, err);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL missing_strobes got %0d pending required 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic fill_random(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    ebreak_E = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || PC_ce !== 1'b0 || Instr_ce !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got core_rst=%b PC_ce=%b Instr_ce=%b rx_ready=%b required 1 0 0 0",
               core_rst, PC_ce, Instr_ce, rx_ready);
    end
    checks++;
    if (instrWrEn !== 1'b0 || InstrWrAdd !== TB_BASE || InstrWrData !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_write got en=%b addr=%h data=%h required 0 %h 00",
               instrWrEn, InstrWrAdd, InstrWrData, TB_BASE);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status got busy=%b done=%b err=%b required 0 0 0", busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_load();
    payload.delete();
    payload.push_back(8'h93);
    payload.push_back(8'h00);
    payload.push_back(8'h10);
    payload.push_back(8'h00);
    run_load(32'd4, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_length();
    run_load(32'd0, 0, 1, 1'b1, 1'b0);
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_clear got err=%b busy=%b rx_ready=%b core_rst=%b required 0 1 1 1",
               err, busy, rx_ready, core_rst);
    end
    fill_random(6);
    run_load(32'd6, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_over_length();
    run_load(TB_SIZE + 1, 0, 1, 1'b1, 1'b0);
    run_load({$urandom_range(1, 255), 24'h0}, 0, 0, 1'b1, 1'b0);
    fill_random(TB_SIZE);
    run_load(TB_SIZE, 0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_stream_gaps();
    fill_random(3);
    run_load(32'd3, 5, 5, 1'b1, 1'b1);
  endtask

  task automatic test_halt_reload();
    fill_random(5);
    run_load(32'd5, 0, 1, 1'b1, 1'b0);
    ebreak_E = 1'b1;
    @(negedge clk);
    ebreak_E = 1'b0;
    checks++;
    if (PC_ce !== 1'b0 || Instr_ce !== 1'b0 || core_rst !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt got PC_ce=%b Instr_ce=%b core_rst=%b done=%b busy=%b required 0 0 0 1 0",
               PC_ce, Instr_ce, core_rst, done, busy);
    end
    pulse_start();
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0 || PC_ce !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reload got core_rst=%b busy=%b rx_ready=%b done=%b PC_ce=%b required 1 1 1 0 0",
               core_rst, busy, rx_ready, done, PC_ce);
    end
    fill_random(7);
    run_load(32'd7, 0, 1, 1'b0, 1'b0);
    start    = 1'b1;
    ebreak_E = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    ebreak_E = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_beats_ebreak got busy=%b done=%b core_rst=%b required 1 0 1",
               busy, done, core_rst);
    end
    fill_random(2);
    run_load(32'd2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random_loads();
    int n;
    repeat (6) begin
      n = $urandom_range(1, TB_SIZE);
      fill_random(n);
      run_load(32'(n), 0, 2, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_load();
    fill_random(8);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 8 : 0), 0, 1'b0, 32'd0, 1'b0);
    send_byte(payload[0], 0, 1'b1, TB_BASE, 1'b0);
    send_byte(payload[1], 1, 1'b1, TB_BASE + 32'd1, 1'b0);
    rx_valid = 1'b1;
    rx_data  = payload[2];
    test_reset();
    rx_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || core_rst !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got pending=%0d core_rst=%b busy=%b rx_ready=%b required 0 1 0 0",
               exp_q.size(), core_rst, busy, rx_ready);
      exp_q.delete();
    end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] x;
    fill_random(4);
    x = payload[0] ^ payload[1] ^ payload[2] ^ payload[3];
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 4 : 0), 0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(payload[i], 0, 1'b1, TB_BASE + 32'(i), 1'b0);
    send_byte(x ^ 8'h01, 0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_checksum got err=%b core_rst=%b done=%b required 1 1 0", err, core_rst, done);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    ebreak_E = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_zero_length();
    test_over_length();
    test_stream_gaps();
    test_halt_reload();
    test_random_loads();
    test_reset_mid_load();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_bad_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
